// File: rtl/rom_pkg.sv
// Shared definitions for the ROM scan initiator: FSM state encoding and default widths.
package rom_pkg;
   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      OUT   = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/rom_reader.sv
// Walks a wrapping ROM address range, registers each returned byte, streams it
// out over valid/ready and keeps a modulo checksum of the bytes read.
module rom_reader
   import rom_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_sel,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   state_t            state, state_n;
   logic [ADDR_W:0]   rem, rem_n;
   logic [ADDR_W-1:0] addr_n;
   logic              sel_n, valid_n, busy_n, done_n;
   logic [DATA_W-1:0] data_n, chk_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rem       <= '0;
         rom_addr  <= '0;
         rom_sel   <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         checksum  <= '0;
      end else begin
         state     <= state_n;
         rem       <= rem_n;
         rom_addr  <= addr_n;
         rom_sel   <= sel_n;
         out_data  <= data_n;
         out_valid <= valid_n;
         busy      <= busy_n;
         done      <= done_n;
         checksum  <= chk_n;
      end
   end

   always_comb begin
      state_n = state;
      rem_n   = rem;
      addr_n  = rom_addr;
      sel_n   = rom_sel;
      data_n  = out_data;
      valid_n = out_valid;
      busy_n  = busy;
      done_n  = done;
      chk_n   = checksum;
      case (state)
         // DONE accepts a start exactly like IDLE so scans can run back to back
         IDLE, DONE: begin
            state_n = IDLE;
            done_n  = 1'b0;
            busy_n  = 1'b0;
            if (start) begin
               chk_n = '0;
               if (count == '0) begin
                  rem_n   = '0;
                  done_n  = 1'b1;
                  state_n = DONE;
               end else begin
                  rem_n   = count;
                  addr_n  = base;
                  sel_n   = 1'b1;
                  busy_n  = 1'b1;
                  state_n = SETUP;
               end
            end
         end
         SETUP: begin
            data_n  = rom_data;
            chk_n   = checksum + rom_data;
            sel_n   = 1'b0;
            valid_n = 1'b1;
            state_n = OUT;
         end
         OUT: begin
            // out_valid is always high in OUT, so ready alone completes the handshake
            if (out_ready) begin
               valid_n = 1'b0;
               if (rem > 1) begin
                  addr_n  = rom_addr + 1'b1;
                  sel_n   = 1'b1;
                  rem_n   = rem - 1'b1;
                  state_n = SETUP;
               end else begin
                  rem_n   = '0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = DONE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader: a queue-based scan model checked every cycle,
// plus hand-computed literals for latency, checksums and reset behaviour.
module tb_rom_reader;
   logic       clk, rst_n, start, rom_sel, out_valid, out_ready, busy, done;
   logic [2:0] base, rom_addr;
   logic [3:0] count;
   logic [7:0] rom_data, out_data, checksum;

   logic [7:0] rom_mem [8];
   assign rom_data = rom_sel ? rom_mem[rom_addr] : 8'h00;

   rom_reader #(.ADDR_W(3), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
      .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done), .checksum(checksum)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vec = 0, errs = 0, ndone = 0, nhs = 0;
   logic [7:0] run_sum = 8'h00;
   logic [2:0] addr_q[$];
   logic [7:0] data_q[$];
   logic [7:0] sum_q[$];
   int         len_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: the scan is just the list of addresses base, base+1, ... mod 8
   task automatic push_scan(input logic [2:0] b, input logic [3:0] c);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < int'(c); i++) begin
         logic [2:0] a;
         a = 3'((int'(b) + i) % 8);
         addr_q.push_back(a);
         data_q.push_back(rom_mem[a]);
         s = s + rom_mem[a];
      end
      len_q.push_back(int'(c));
      sum_q.push_back(s);
   endtask

   task automatic flush_model();
      addr_q.delete(); data_q.delete(); sum_q.delete(); len_q.delete();
      run_sum = 8'h00;
      nhs = 0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rom_sel) begin
            if (addr_q.size() == 0) chk("sel_without_scan", 1, 0);
            else chk("rom_addr", rom_addr, addr_q[0]);
         end
         if (out_valid) begin
            if (data_q.size() == 0) chk("valid_without_scan", 1, 0);
            else begin
               chk("out_data", out_data, data_q[0]);
               chk("run_checksum", checksum, 8'(run_sum + data_q[0]));
               chk("sel_while_valid", rom_sel, 0);
               if (out_ready) begin
                  run_sum = run_sum + data_q[0];
                  void'(data_q.pop_front());
                  void'(addr_q.pop_front());
                  nhs++;
               end
            end
         end
         if (done) begin
            if (len_q.size() == 0) chk("done_without_scan", 1, 0);
            else begin
               chk("scan_len", nhs, len_q.pop_front());
               chk("done_checksum", checksum, sum_q.pop_front());
            end
            chk("busy_in_done", busy, 0);
            nhs = 0;
            run_sum = 8'h00;
            ndone++;
         end
      end
   end

   task automatic kick(input logic [2:0] b, input logic [3:0] c, input bit model);
      base  = b;
      count = c;
      start = 1'b1;
      if (model) push_scan(b, c);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      while (!done && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   initial begin
      rom_mem = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'hF0};
      start = 0; base = 0; count = 0; out_ready = 1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_outputs", {rom_addr, rom_sel, out_data, out_valid, busy, done, checksum}, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: full ROM, ready held high
      kick(3'd0, 4'd8, 1);
      chk("t1_busy", busy, 1);
      @(posedge clk); #1;
      chk("t1_first_valid", out_valid, 1);
      chk("t1_first_byte", out_data, 8'h11);
      repeat (15) begin @(posedge clk); #1; end
      chk("t1_done_after_E16", done, 1);
      chk("t1_checksum", checksum, 8'hCC);
      @(posedge clk); #1;
      chk("t1_done_pulse", done, 0);
      chk("t1_checksum_hold", checksum, 8'hCC);

      // 2: wrapping range 6,7,0,1
      kick(3'd6, 4'd4, 1);
      wait_done(20);
      chk("t2_checksum", checksum, 8'h9A);
      @(posedge clk); #1;

      // 3: back-pressure on byte 2
      kick(3'd3, 4'd4, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         chk("t3_hold_valid", out_valid, 1);
         chk("t3_hold_data", out_data, 8'h55);
         chk("t3_hold_sel", rom_sel, 0);
         chk("t3_hold_addr", rom_addr, 3'd4);
      end
      out_ready = 1'b1;
      wait_done(20);
      chk("t3_checksum", checksum, 8'h76);
      @(posedge clk); #1;

      // 4: empty scan
      kick(3'd5, 4'd0, 1);
      chk("t4_done", done, 1);
      chk("t4_checksum", checksum, 0);
      chk("t4_no_sel", rom_sel, 0);
      @(posedge clk); #1;
      chk("t4_done_pulse", done, 0);

      // 5: start/base/count during a scan are ignored; start in DONE chains
      kick(3'd2, 4'd3, 1);
      @(posedge clk); #1;
      base = 3'd7; count = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; base = 3'd0; count = 4'd15;
      wait_done(30);
      chk("t5_checksum", checksum, 8'hCC);
      kick(3'd1, 4'd2, 1);
      chk("t5_chain_busy", busy, 1);
      chk("t5_chain_sel", rom_sel, 1);
      chk("t5_chain_addr", rom_addr, 3'd1);
      wait_done(20);
      chk("t5_chain_checksum", checksum, 8'h55);
      @(posedge clk); #1;

      // 6: async reset in OUT with out_valid high
      kick(3'd0, 4'd8, 1);
      @(posedge clk); #1;
      chk("t6_valid_before_reset", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_clear", {rom_addr, rom_sel, out_data, out_valid, busy, done, checksum}, 0);
      flush_model();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      kick(3'd5, 4'd3, 1);
      chk("t6_restart_addr", rom_addr, 3'd5);
      wait_done(20);
      chk("t6_checksum", checksum, 8'hCD);
      @(posedge clk); #1;
      @(posedge clk); #1;

      chk("done_pulses", ndone, 7);
      chk("model_drained", data_q.size() + len_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
